// File: rtl/conv2d_multikernel_stream.sv
// Streaming multi-kernel 2-D convolution: loads one image plus NUM_KERNELS KxK kernels,
// then accumulates one kernel row per cycle and emits each result on a back-pressured stream.
module conv2d_multikernel_stream #(
  parameter int INPUT_DIM   = 28,
  parameter int KERNEL_SIZE = 5,
  parameter int STRIDE      = 1,
  parameter int NUM_KERNELS = 4,
  parameter int INBITWIDTH  = 8,
  parameter int OUTBITWIDTH = 25,
  parameter int SIGNED_MODE = 0,
  localparam int OUTPUT_DIM = (INPUT_DIM - KERNEL_SIZE) / STRIDE + 1,
  localparam int KNW        = (NUM_KERNELS > 1) ? $clog2(NUM_KERNELS) : 1,
  localparam int ODW        = (OUTPUT_DIM > 1) ? $clog2(OUTPUT_DIM) : 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   keep_wts,
  input  logic                   relu_en,
  input  logic                   pix_valid,
  output logic                   pix_ready,
  input  logic [INBITWIDTH-1:0]  pix_data,
  input  logic                   wt_valid,
  output logic                   wt_ready,
  input  logic [INBITWIDTH-1:0]  wt_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OUTBITWIDTH-1:0] out_data,
  output logic [KNW-1:0]         out_kernel,
  output logic [ODW-1:0]         out_row,
  output logic [ODW-1:0]         out_col,
  output logic                   out_last,
  output logic                   busy,
  output logic                   done
);

  localparam int K    = KERNEL_SIZE;
  localparam int NPIX = INPUT_DIM * INPUT_DIM;
  localparam int NWT  = NUM_KERNELS * K * K;
  localparam int PCW  = $clog2(NPIX + 1);
  localparam int WCW  = $clog2(NWT + 1);
  localparam int PAW  = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int WAW  = (NWT > 1) ? $clog2(NWT) : 1;
  localparam int KRW  = (K > 1) ? $clog2(K) : 1;
  localparam int PW   = 2 * INBITWIDTH;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_COMPUTE = 3'd2,
    S_EMIT    = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic [INBITWIDTH-1:0]  img_q [NPIX];
  logic [INBITWIDTH-1:0]  wt_q  [NWT];

  logic [PCW-1:0]         pix_cnt_q, pix_cnt_d;
  logic [WCW-1:0]         wt_cnt_q, wt_cnt_d;
  logic [KRW-1:0]         kr_q, kr_d;
  logic [KNW-1:0]         kn_q, kn_d;
  logic [ODW-1:0]         orow_q, orow_d;
  logic [ODW-1:0]         ocol_q, ocol_d;
  logic [OUTBITWIDTH-1:0] acc_q, acc_d;
  logic                   relu_q, relu_d;
  logic                   wts_loaded_q, wts_loaded_d;

  logic                   pix_xfer, wt_xfer;
  logic                   pix_full, wt_full;
  logic                   col_end, row_end, kern_end, last_pix;
  logic [OUTBITWIDTH-1:0] row_sum;
  logic [PAW-1:0]         img_idx;
  logic [WAW-1:0]         wt_idx;
  logic [INBITWIDTH-1:0]  op_a, op_b;
  logic [PW-1:0]          ext_a, ext_b, prod;

  assign pix_full  = (pix_cnt_q == PCW'(NPIX));
  assign wt_full   = (wt_cnt_q == WCW'(NWT));
  assign pix_ready = (state_q == S_LOAD) && !pix_full;
  assign wt_ready  = (state_q == S_LOAD) && !wt_full;
  assign pix_xfer  = pix_valid && pix_ready;
  assign wt_xfer   = wt_valid && wt_ready;

  assign col_end  = (ocol_q == ODW'(OUTPUT_DIM - 1));
  assign row_end  = (orow_q == ODW'(OUTPUT_DIM - 1));
  assign kern_end = (kn_q == KNW'(NUM_KERNELS - 1));
  assign last_pix = col_end && row_end && kern_end;

  // Buffers hold data across reset on purpose; only wts_loaded_q decides if they are usable.
  always_ff @(posedge clk) begin
    if (pix_xfer) img_q[pix_cnt_q[PAW-1:0]] <= pix_data;
    if (wt_xfer)  wt_q[wt_cnt_q[WAW-1:0]]   <= wt_data;
  end

  // One kernel row of the current output pixel; products wrap at PW bits before extension.
  always_comb begin
    row_sum = '0;
    img_idx = '0;
    wt_idx  = '0;
    op_a    = '0;
    op_b    = '0;
    ext_a   = '0;
    ext_b   = '0;
    prod    = '0;
    for (int j = 0; j < K; j++) begin
      img_idx = PAW'((int'(orow_q) * STRIDE + int'(kr_q)) * INPUT_DIM + int'(ocol_q) * STRIDE + j);
      wt_idx  = WAW'((int'(kn_q) * K + int'(kr_q)) * K + j);
      op_a    = img_q[img_idx];
      op_b    = wt_q[wt_idx];
      ext_a   = (SIGNED_MODE != 0) ? PW'($signed(op_a)) : PW'(op_a);
      ext_b   = (SIGNED_MODE != 0) ? PW'($signed(op_b)) : PW'(op_b);
      prod    = ext_a * ext_b;
      if (SIGNED_MODE != 0) row_sum = row_sum + OUTBITWIDTH'($signed(prod));
      else                  row_sum = row_sum + OUTBITWIDTH'(prod);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      pix_cnt_q    <= '0;
      wt_cnt_q     <= '0;
      kr_q         <= '0;
      kn_q         <= '0;
      orow_q       <= '0;
      ocol_q       <= '0;
      acc_q        <= '0;
      relu_q       <= 1'b0;
      wts_loaded_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pix_cnt_q    <= pix_cnt_d;
      wt_cnt_q     <= wt_cnt_d;
      kr_q         <= kr_d;
      kn_q         <= kn_d;
      orow_q       <= orow_d;
      ocol_q       <= ocol_d;
      acc_q        <= acc_d;
      relu_q       <= relu_d;
      wts_loaded_q <= wts_loaded_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pix_cnt_d    = pix_cnt_q;
    wt_cnt_d     = wt_cnt_q;
    kr_d         = kr_q;
    kn_d         = kn_q;
    orow_d       = orow_q;
    ocol_d       = ocol_q;
    acc_d        = acc_q;
    relu_d       = relu_q;
    wts_loaded_d = wts_loaded_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          relu_d    = relu_en;
          pix_cnt_d = '0;
          // Marking the weight counter full is how a reuse frame skips the weight stream.
          wt_cnt_d  = (keep_wts && wts_loaded_q) ? WCW'(NWT) : '0;
          kr_d      = '0;
          kn_d      = '0;
          orow_d    = '0;
          ocol_d    = '0;
          state_d   = S_LOAD;
        end
      end
      S_LOAD: begin
        if (pix_xfer) pix_cnt_d = pix_cnt_q + PCW'(1);
        if (wt_xfer)  wt_cnt_d  = wt_cnt_q + WCW'(1);
        if (pix_full && wt_full) begin
          wts_loaded_d = 1'b1;
          kr_d         = '0;
          state_d      = S_COMPUTE;
        end
      end
      S_COMPUTE: begin
        acc_d = (kr_q == '0) ? row_sum : acc_q + row_sum;
        if (kr_q == KRW'(K - 1)) begin
          kr_d    = '0;
          state_d = S_EMIT;
        end else begin
          kr_d = kr_q + KRW'(1);
        end
      end
      S_EMIT: begin
        if (out_ready) begin
          if (last_pix) begin
            state_d = S_DONE;
          end else begin
            state_d = S_COMPUTE;
            if (col_end) begin
              ocol_d = '0;
              if (row_end) begin
                orow_d = '0;
                kn_d   = kn_q + KNW'(1);
              end else begin
                orow_d = orow_q + ODW'(1);
              end
            end else begin
              ocol_d = ocol_q + ODW'(1);
            end
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign out_valid  = (state_q == S_EMIT);
  assign out_last   = (state_q == S_EMIT) && last_pix;
  assign out_data   = ((SIGNED_MODE != 0) && relu_q && acc_q[OUTBITWIDTH-1]) ? '0 : acc_q;
  assign out_kernel = kn_q;
  assign out_row    = orow_q;
  assign out_col    = ocol_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);

endmodule

// File: tb/tb_conv2d_multikernel_stream.sv
// Randomised bench for conv2d_multikernel_stream (signed, stride 2, two kernels) against a
// plain-arithmetic convolution model, including weight reuse, stalls and mid-frame resets.
module tb_conv2d_multikernel_stream;

  localparam int ID    = 7;
  localparam int K     = 3;
  localparam int S     = 2;
  localparam int NK    = 2;
  localparam int INW   = 8;
  localparam int OUTW  = 25;
  localparam int OD    = (ID - K) / S + 1;
  localparam int NPIX  = ID * ID;
  localparam int NWT   = NK * K * K;
  localparam int TOTAL = NK * OD * OD;
  localparam int KNW   = (NK > 1) ? $clog2(NK) : 1;
  localparam int ODW   = (OD > 1) ? $clog2(OD) : 1;

  logic            clk = 1'b0;
  logic            reset_n, start, keep_wts, relu_en;
  logic            pix_valid, pix_ready, wt_valid, wt_ready;
  logic [INW-1:0]  pix_data, wt_data;
  logic            out_valid, out_ready, out_last, busy, done;
  logic [OUTW-1:0] out_data;
  logic [KNW-1:0]  out_kernel;
  logic [ODW-1:0]  out_row, out_col;

  always #5 clk = ~clk;

  conv2d_multikernel_stream #(
    .INPUT_DIM(ID), .KERNEL_SIZE(K), .STRIDE(S), .NUM_KERNELS(NK),
    .INBITWIDTH(INW), .OUTBITWIDTH(OUTW), .SIGNED_MODE(1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .keep_wts(keep_wts), .relu_en(relu_en),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .wt_valid(wt_valid), .wt_ready(wt_ready), .wt_data(wt_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_kernel(out_kernel), .out_row(out_row), .out_col(out_col),
    .out_last(out_last), .busy(busy), .done(done)
  );

  int n_checks = 0;
  int n_errors = 0;

  int img_m [NPIX];
  int wt_m  [NWT];
  int wt_loaded_m [NWT];
  bit model_wts_valid = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [OUTW-1:0] ref_pixel(input int kn, input int r, input int c, input bit relu);
    longint s = 0;
    for (int ky = 0; ky < K; ky++)
      for (int kx = 0; kx < K; kx++)
        s += longint'(img_m[(r * S + ky) * ID + c * S + kx]) * longint'(wt_loaded_m[kn * K * K + ky * K + kx]);
    if (relu && s < 0) s = 0;
    return OUTW'(s);
  endfunction

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_last"}, out_last, 0);
    chk({tag, "_data"}, out_data, 0);
    chk({tag, "_pix_rdy"}, pix_ready, 0);
    chk({tag, "_wt_rdy"}, wt_ready, 0);
    chk({tag, "_idx"}, {out_kernel, out_row, out_col}, 0);
  endtask

  task automatic fill_random();
    for (int i = 0; i < NPIX; i++) img_m[i] = int'($urandom_range(0, 255)) - 128;
    for (int i = 0; i < NWT; i++)  wt_m[i]  = int'($urandom_range(0, 255)) - 128;
  endtask

  // abort_mode: 0 none, 1 reset during COMPUTE, 2 reset during an EMIT stall
  task automatic run_frame(input bit keep, input bit relu, input int gap_pct, input int stall_pct,
                           input int abort_mode, input bit poke_start);
    int pix_i = 0, wt_i = 0, res_i = 0, cycles = 0, done_cnt = 0, extra_rdy = 0, done_phase = 0;
    bit full_load, wt_rdy_seen = 0, stalled = 0, poked = 0, aborted = 0, fin = 0;
    logic [OUTW-1:0] h_data;
    logic [KNW-1:0]  h_kn;
    logic [ODW-1:0]  h_row, h_col;
    logic            h_last;
    int kn, r, c;

    full_load = !(keep && model_wts_valid);
    if (full_load) wt_loaded_m = wt_m;

    @(negedge clk);
    start = 1'b1; keep_wts = keep; relu_en = relu;
    @(negedge clk);
    start = 1'b0; keep_wts = ~keep; relu_en = ~relu;

    while (!fin) begin
      cycles++;
      if (poked) begin start = 1'b0; end
      if ((abort_mode == 1 && pix_i == NPIX && res_i >= 2 && busy && !out_valid) ||
          (abort_mode == 2 && out_valid && stalled && res_i >= 3)) begin
        #1 reset_n = 1'b0;
        #1 check_idle_outputs(abort_mode == 1 ? "rst_compute" : "rst_emit");
        model_wts_valid = 1'b0;
        aborted = 1'b1;
        pix_valid = 1'b0; wt_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk); @(negedge clk);
        reset_n = 1'b1;
        break;
      end

      if (done_phase == 1) begin
        chk("done_pulse", done, 1);
        done_phase = 2;
      end else if (done_phase == 2) begin
        chk("done_drop", done, 0);
        chk("busy_drop", busy, 0);
        fin = 1'b1;
      end
      if (done) done_cnt++;
      if (wt_ready) wt_rdy_seen = 1'b1;
      if (pix_i == NPIX && pix_ready) extra_rdy++;
      if (wt_i == NWT && wt_ready) extra_rdy++;

      if (out_valid) begin
        if (stalled) begin
          chk("hold_data", out_data, h_data);
          chk("hold_idx", {out_kernel, out_row, out_col}, {h_kn, h_row, h_col});
          chk("hold_last", out_last, h_last);
        end
        out_ready = ($urandom_range(0, 99) >= stall_pct);
        if (abort_mode == 2 && res_i >= 3) out_ready = 1'b0;
        if (out_ready) begin
          if (res_i < TOTAL) begin
            kn = res_i / (OD * OD); r = (res_i / OD) % OD; c = res_i % OD;
            chk("data", out_data, ref_pixel(kn, r, c, relu));
            chk("kernel", out_kernel, kn);
            chk("row", out_row, r);
            chk("col", out_col, c);
            chk("last", out_last, (res_i == TOTAL - 1));
          end else begin
            chk("extra_result", 1, 0);
          end
          if (out_last) done_phase = 1;
          res_i++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          h_data = out_data; h_kn = out_kernel; h_row = out_row; h_col = out_col; h_last = out_last;
        end
      end else begin
        out_ready = $urandom_range(0, 1) == 1;
      end

      if (pix_i < NPIX) begin
        pix_valid = ($urandom_range(0, 99) >= gap_pct);
        pix_data  = INW'(img_m[pix_i]);
      end else begin
        pix_valid = 1'b1;
        pix_data  = INW'($urandom);
      end
      if (pix_valid && pix_ready && pix_i < NPIX) pix_i++;

      if (wt_i < NWT) begin
        wt_valid = ($urandom_range(0, 99) >= gap_pct);
        wt_data  = INW'(wt_m[wt_i]);
      end else begin
        wt_valid = 1'b1;
        wt_data  = INW'($urandom);
      end
      if (wt_valid && wt_ready && wt_i < NWT) wt_i++;

      if (poke_start && !poked && res_i == 1) begin
        start = 1'b1; keep_wts = $urandom_range(0, 1) == 1; relu_en = ~relu;
        poked = 1'b1;
      end

      if (cycles > 5000) begin
        chk("timeout", 1, 0);
        fin = 1'b1;
      end
      if (!fin) @(negedge clk);
    end

    start = 1'b0; pix_valid = 1'b0; wt_valid = 1'b0; out_ready = 1'b0;
    if (!aborted) begin
      chk("result_count", res_i, TOTAL);
      chk("done_count", done_cnt, 1);
      chk("extra_ready", extra_rdy, 0);
      chk("pix_beats", pix_i, NPIX);
      chk("wt_ready_seen", wt_rdy_seen, full_load);
      chk("wt_beats", wt_i, full_load ? NWT : 0);
      model_wts_valid = 1'b1;
    end
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; keep_wts = 1'b0; relu_en = 1'b0;
    pix_valid = 1'b0; wt_valid = 1'b0; out_ready = 1'b0;
    pix_data = '0; wt_data = '0;
    #2 check_idle_outputs("reset");
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;

    // Ramp image, kernel0 = centre tap, kernel1 = top-left tap
    for (int i = 0; i < NPIX; i++) img_m[i] = i;
    for (int i = 0; i < NWT; i++)  wt_m[i] = 0;
    wt_m[4] = 1;
    wt_m[9] = 1;
    run_frame(1'b0, 1'b0, 0, 0, 0, 1'b0);

    // Extreme signed operands, then the same frame reusing weights with ReLU
    for (int i = 0; i < NPIX; i++) img_m[i] = -128;
    for (int i = 0; i < NWT; i++)  wt_m[i] = 127;
    run_frame(1'b0, 1'b0, 20, 20, 0, 1'b0);
    run_frame(1'b1, 1'b1, 20, 20, 0, 1'b0);

    for (int f = 0; f < 3; f++) begin
      fill_random();
      run_frame(1'b0, f == 1, 30, 40, 0, 1'b0);
    end

    // Reuse: new weight values are offered but must not be taken
    fill_random();
    run_frame(1'b1, 1'b0, 30, 30, 0, 1'b0);

    fill_random();
    run_frame(1'b0, 1'b0, 10, 10, 1, 1'b0);
    run_frame(1'b1, 1'b0, 10, 30, 0, 1'b0);

    fill_random();
    run_frame(1'b0, 1'b1, 10, 10, 2, 1'b0);
    fill_random();
    run_frame(1'b0, 1'b1, 25, 25, 0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
